// File: rtl/reg_write_arbiter.sv
// Shares the register file write port between writeback (A, priority) and a
// buffered long-latency writer (B). Also flags reads that have a write in flight.
module reg_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    input  logic [4:0]               a_addr,
    input  logic [31:0]              a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [4:0]               b_addr,
    input  logic [31:0]              b_data,
    output logic                     wr,
    output logic [4:0]               addr3,
    output logic [31:0]              data3,
    input  logic [4:0]               addr1,
    input  logic [4:0]               addr2,
    output logic                     hit1,
    output logic                     hit2,
    output logic                     a_hold,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     hold_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            wr_q, wr_d, hold_err_q, hold_err_d;
    logic [4:0]      addr3_q, addr3_d;
    logic [31:0]     data3_q, data3_d;
    logic            push, pop, a_take;

    assign b_ready = (count_q < DEPTH_C);
    assign a_hold  = (starve_q == LIMIT_C);
    assign push    = b_valid && b_ready && (b_addr != 5'd0);
    assign a_take  = a_valid && (a_addr != 5'd0);
    // An A request to $0 still occupies the port: no pop that cycle.
    assign pop     = !a_valid && (count_q != '0);

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch.
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        wr_d       = a_take || pop;
        addr3_d    = addr3_q;
        data3_d    = data3_q;
        hold_err_d = hold_err_q || (a_valid && a_hold);

        if (a_take) begin
            addr3_d = a_addr;
            data3_d = a_data;
        end else if (pop) begin
            addr3_d  = mem_q[rd_ptr_q].addr;
            data3_d  = mem_q[rd_ptr_q].data;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{addr: b_addr, data: b_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop || count_q == '0) begin
            starve_d = '0;
        end else if (a_valid && starve_q != LIMIT_C) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            wr_q       <= 1'b0;
            addr3_q    <= '0;
            data3_q    <= '0;
            hold_err_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            wr_q       <= wr_d;
            addr3_q    <= addr3_d;
            data3_q    <= data3_d;
            hold_err_q <= hold_err_d;
        end
    end

    // NOTE: storage is not reset; entries outside count are never observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        logic [PW-1:0] idx;
        hit1 = wr_q && (addr3_q == addr1);
        hit2 = wr_q && (addr3_q == addr2);
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (mem_q[idx].addr == addr1) hit1 = 1'b1;
                if (mem_q[idx].addr == addr2) hit2 = 1'b1;
            end
        end
        hit1 = hit1 && (addr1 != 5'd0);
        hit2 = hit2 && (addr2 != 5'd0);
    end

    assign wr       = wr_q;
    assign addr3    = addr3_q;
    assign data3    = data3_q;
    assign count    = count_q;
    assign hold_err = hold_err_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: A path, B ordering, full FIFO,
// starvation/hold, $0 handling and mid-operation reset.
module tb_reg_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, b_ready;
    logic [4:0]  a_addr, b_addr, addr1, addr2, addr3;
    logic [31:0] a_data, b_data, data3;
    logic        wr, hit1, hit2, a_hold, hold_err;
    logic [2:0]  count;

    int tests_run = 0;
    int fails     = 0;

    reg_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr(wr), .addr3(addr3), .data3(data3),
        .addr1(addr1), .addr2(addr2), .hit1(hit1), .hit2(hit2),
        .a_hold(a_hold), .count(count), .hold_err(hold_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        addr1 = '0; addr2 = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        addr1 = 5'd5; addr2 = 5'd31;
        #1;
        tests_run++; if (wr !== 1'b0) begin fails++; $display("FAIL reset_wr: got %0b want 0", wr); end
        tests_run++; if (addr3 !== 5'd0) begin fails++; $display("FAIL reset_addr3: got %0d want 0", addr3); end
        tests_run++; if (data3 !== 32'd0) begin fails++; $display("FAIL reset_data3: got %h want 0", data3); end
        tests_run++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests_run++; if (b_ready !== 1'b1) begin fails++; $display("FAIL reset_b_ready: got %0b want 1", b_ready); end
        tests_run++; if (a_hold !== 1'b0) begin fails++; $display("FAIL reset_a_hold: got %0b want 0", a_hold); end
        tests_run++; if (hold_err !== 1'b0) begin fails++; $display("FAIL reset_hold_err: got %0b want 0", hold_err); end
        tests_run++; if ({hit1, hit2} !== 2'b00) begin fails++; $display("FAIL reset_hits: got %b want 00", {hit1, hit2}); end
    endtask

    task automatic test_a_only;
        do_reset();
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h0000_FFFF; addr1 = 5'd10;
        tick();
        a_valid = 1'b0;
        #1;
        tests_run++; if (wr !== 1'b1) begin fails++; $display("FAIL a_wr: got %0b want 1", wr); end
        tests_run++; if (addr3 !== 5'd10) begin fails++; $display("FAIL a_addr3: got %0d want 10", addr3); end
        tests_run++; if (data3 !== 32'h0000_FFFF) begin fails++; $display("FAIL a_data3: got %h want 0000ffff", data3); end
        tests_run++; if (hit1 !== 1'b1) begin fails++; $display("FAIL a_hit1: got %0b want 1", hit1); end
        tick();
        tests_run++; if (wr !== 1'b0) begin fails++; $display("FAIL a_wr_after: got %0b want 0", wr); end
        tests_run++; if (addr3 !== 5'd10) begin fails++; $display("FAIL a_addr3_hold: got %0d want 10", addr3); end
        tests_run++; if (hit1 !== 1'b0) begin fails++; $display("FAIL a_hit1_after: got %0b want 0", hit1); end
    endtask

    task automatic test_b_order;
        do_reset();
        addr2 = 5'd31;
        b_valid = 1'b1; b_addr = 5'd14; b_data = 32'h0000_FF00;
        tick();
        tests_run++; if (count !== 3'd1) begin fails++; $display("FAIL b_count1: got %0d want 1", count); end
        tests_run++; if (wr !== 1'b0) begin fails++; $display("FAIL b_wr_early: got %0b want 0", wr); end
        b_addr = 5'd31; b_data = 32'h0000_AAAA;
        tick();
        tests_run++; if ({wr, addr3} !== {1'b1, 5'd14}) begin fails++; $display("FAIL b_first: got wr=%0b addr=%0d want wr=1 addr=14", wr, addr3); end
        tests_run++; if (data3 !== 32'h0000_FF00) begin fails++; $display("FAIL b_first_data: got %h want 0000ff00", data3); end
        tests_run++; if (hit2 !== 1'b1) begin fails++; $display("FAIL b_hit2_queued: got %0b want 1", hit2); end
        tests_run++; if (count !== 3'd1) begin fails++; $display("FAIL b_count_pushpop: got %0d want 1", count); end
        b_addr = 5'd1; b_data = 32'h0000_8888;
        tick();
        b_valid = 1'b0;
        #1;
        tests_run++; if ({wr, addr3} !== {1'b1, 5'd31}) begin fails++; $display("FAIL b_second: got wr=%0b addr=%0d want wr=1 addr=31", wr, addr3); end
        tests_run++; if (data3 !== 32'h0000_AAAA) begin fails++; $display("FAIL b_second_data: got %h want 0000aaaa", data3); end
        tests_run++; if (hit2 !== 1'b1) begin fails++; $display("FAIL b_hit2_wr: got %0b want 1", hit2); end
        tick();
        tests_run++; if ({wr, addr3} !== {1'b1, 5'd1}) begin fails++; $display("FAIL b_third: got wr=%0b addr=%0d want wr=1 addr=1", wr, addr3); end
        tests_run++; if (data3 !== 32'h0000_8888) begin fails++; $display("FAIL b_third_data: got %h want 00008888", data3); end
        tests_run++; if (hit2 !== 1'b0) begin fails++; $display("FAIL b_hit2_done: got %0b want 0", hit2); end
        tick();
        tests_run++; if ({wr, count} !== {1'b0, 3'd0}) begin fails++; $display("FAIL b_drained: got wr=%0b count=%0d want wr=0 count=0", wr, count); end
    endtask

    task automatic test_full;
        logic [4:0] ba [4];
        ba[0] = 5'd2; ba[1] = 5'd3; ba[2] = 5'd4; ba[3] = 5'd6;
        do_reset();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h5555_0000;
        for (int i = 0; i < 4; i++) begin
            b_valid = 1'b1; b_addr = ba[i]; b_data = 32'hB000_0000 + 32'(i);
            #1;
            tests_run++; if (b_ready !== 1'b1) begin fails++; $display("FAIL full_ready_%0d: got %0b want 1", i, b_ready); end
            tick();
            tests_run++; if (count !== 3'(i + 1)) begin fails++; $display("FAIL full_count_%0d: got %0d want %0d", i, count, i + 1); end
        end
        tests_run++; if (b_ready !== 1'b0) begin fails++; $display("FAIL full_not_ready: got %0b want 0", b_ready); end
        b_addr = 5'd7; b_data = 32'hDEAD_BEEF; addr1 = 5'd7;
        tick();
        tests_run++; if (count !== 3'd4) begin fails++; $display("FAIL full_fifth_count: got %0d want 4", count); end
        tests_run++; if (hit1 !== 1'b0) begin fails++; $display("FAIL full_fifth_hit: got %0b want 0", hit1); end
        tests_run++; if ({wr, addr3} !== {1'b1, 5'd5}) begin fails++; $display("FAIL full_a_wins: got wr=%0b addr=%0d want wr=1 addr=5", wr, addr3); end
        addr1 = 5'd6;
        #1;
        tests_run++; if (hit1 !== 1'b1) begin fails++; $display("FAIL full_tail_hit: got %0b want 1", hit1); end
        b_valid = 1'b0; a_valid = 1'b0;
        tick();
        tests_run++; if ({wr, addr3} !== {1'b1, 5'd2}) begin fails++; $display("FAIL full_pop_head: got wr=%0b addr=%0d want wr=1 addr=2", wr, addr3); end
        repeat (3) tick();
        tests_run++; if ({addr3, data3} !== {5'd6, 32'hB000_0003}) begin fails++; $display("FAIL full_pop_tail: got addr=%0d data=%h want addr=6 data=b0000003", addr3, data3); end
        tests_run++; if ({count, b_ready} !== {3'd0, 1'b1}) begin fails++; $display("FAIL full_empty: got count=%0d ready=%0b want count=0 ready=1", count, b_ready); end
    endtask

    task automatic test_starvation;
        do_reset();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hA000_0001;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h0000_0099;
        tick();
        b_valid = 1'b0;
        for (int e = 2; e <= 9; e++) begin
            a_data = 32'hA000_0000 + 32'(e);
            tick();
            if (e == 8) begin
                tests_run++; if (a_hold !== 1'b0) begin fails++; $display("FAIL starve_hold_early: got %0b want 0", a_hold); end
            end
        end
        tests_run++; if (a_hold !== 1'b1) begin fails++; $display("FAIL starve_hold: got %0b want 1", a_hold); end
        tests_run++; if (hold_err !== 1'b0) begin fails++; $display("FAIL starve_err_early: got %0b want 0", hold_err); end
        tests_run++; if (count !== 3'd1) begin fails++; $display("FAIL starve_count: got %0d want 1", count); end
        a_data = 32'hA000_000A;
        tick();
        tests_run++; if (hold_err !== 1'b1) begin fails++; $display("FAIL starve_err_set: got %0b want 1", hold_err); end
        tests_run++; if ({wr, addr3, data3} !== {1'b1, 5'd5, 32'hA000_000A}) begin fails++; $display("FAIL starve_a_still_wins: got wr=%0b addr=%0d data=%h want wr=1 addr=5 data=a000000a", wr, addr3, data3); end
        tests_run++; if (a_hold !== 1'b1) begin fails++; $display("FAIL starve_hold_sat: got %0b want 1", a_hold); end
        a_valid = 1'b0;
        tick();
        tests_run++; if ({wr, addr3, data3} !== {1'b1, 5'd9, 32'h0000_0099}) begin fails++; $display("FAIL starve_pop: got wr=%0b addr=%0d data=%h want wr=1 addr=9 data=00000099", wr, addr3, data3); end
        tests_run++; if ({count, a_hold} !== {3'd0, 1'b0}) begin fails++; $display("FAIL starve_release: got count=%0d hold=%0b want count=0 hold=0", count, a_hold); end
        tests_run++; if (hold_err !== 1'b1) begin fails++; $display("FAIL starve_err_sticky: got %0b want 1", hold_err); end
    endtask

    task automatic test_zero_and_reset;
        do_reset();
        tests_run++; if (hold_err !== 1'b0) begin fails++; $display("FAIL zero_err_cleared: got %0b want 0", hold_err); end
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1234_5678;
        tick();
        a_valid = 1'b0;
        tests_run++; if (wr !== 1'b0) begin fails++; $display("FAIL zero_a_wr: got %0b want 0", wr); end
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h8765_4321;
        #1;
        tests_run++; if (b_ready !== 1'b1) begin fails++; $display("FAIL zero_b_ready: got %0b want 1", b_ready); end
        tick();
        b_valid = 1'b0;
        tests_run++; if (count !== 3'd0) begin fails++; $display("FAIL zero_b_count: got %0d want 0", count); end
        tick();
        tests_run++; if (wr !== 1'b0) begin fails++; $display("FAIL zero_b_wr: got %0b want 0", wr); end
        tests_run++; if ({hit1, hit2} !== 2'b00) begin fails++; $display("FAIL zero_hits: got %b want 00", {hit1, hit2}); end

        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0000_0005;
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1; b_addr = 5'd11 + 5'(i); b_data = 32'hC000_0000 + 32'(i);
            tick();
        end
        tests_run++; if (count !== 3'd3) begin fails++; $display("FAIL rst_prefill: got %0d want 3", count); end
        rst = 1'b1; b_addr = 5'd20;
        tick();
        tests_run++; if ({count, wr, b_ready} !== {3'd0, 1'b0, 1'b1}) begin fails++; $display("FAIL rst_mid: got count=%0d wr=%0b ready=%0b want 0 0 1", count, wr, b_ready); end
        tests_run++; if ({addr3, data3} !== {5'd0, 32'd0}) begin fails++; $display("FAIL rst_mid_port: got addr=%0d data=%h want 0 0", addr3, data3); end
        rst = 1'b0; idle_inputs(); addr1 = 5'd11;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if ({wr, hit1} !== 2'b00) begin fails++; $display("FAIL rst_no_ghost_%0d: got wr=%0b hit1=%0b want 0 0", i, wr, hit1); end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_a_only();
        test_b_order();
        test_full();
        test_starvation();
        test_zero_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the register file's single write port (wr, addr3, data3) between two writers: the pipeline writeback stage (port A, never stalled) and a long-latency unit such as the load/multiply-divide path (port B, valid/ready handshake, buffered). Port A has priority. A bounded starvation counter guarantees B progress, and pending-write hit flags for the read addresses (addr1, addr2) let the hazard unit stall reads of registers whose write has not yet landed. Register $0 writes are discarded.

## Interface
- DEPTH, 4, B-side FIFO entries; power of two, ≥ 2
- STARVE_LIMIT, 8, consecutive A-wins with B pending before a_hold asserts; ≥ 1
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  writeback request, always accepted
- a_addr  in  5  writeback destination register
- a_data  in  32  writeback data
- b_valid  in  1  long-latency request
- b_ready  out  1  B accepted at the edge when b_valid & b_ready
- b_addr  in  5  B destination register
- b_data  in  32  B data
- wr  out  1  register file write enable (registered)
- addr3  out  5  register file write address (registered)
- data3  out  32  register file write data (registered)
- addr1, addr2  in  5 each  current register file read addresses
- hit1, hit2  out  1 each  read address has an undelivered write (combinational)
- a_hold  out  1  upstream must not present a_valid this cycle
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- hold_err  out  1  sticky: a_valid seen while a_hold high

## Operation
- FIFO: circular buffer with rd_ptr/wr_ptr and occupancy count. b_ready = (count < DEPTH), computed from registered count only. A push while full is therefore impossible even if a pop occurs in the same cycle.
- B request with b_addr == 0: handshake completes (b_ready rules apply) and nothing is enqueued.
- Selection each cycle, registered at the edge:
  - if a_valid & a_addr != 0: the write port loads A;
  - else if a_valid & a_addr == 0: wr = 0 and no pop;
  - else if count > 0: pop the head entry into the write port;
  - else wr = 0.
- addr3/data3 hold their last value when wr = 0.
- Push and pop in the same cycle are legal; count stays unchanged.
- An entry pushed at edge N is not poppable before cycle N+1. There is no bypass.
- Starvation counter:
  - increments (saturating at STARVE_LIMIT) in each cycle where A wins and count > 0;
  - clears on any pop, and when count == 0.
- a_hold = (counter == STARVE_LIMIT).
- If a_valid is high while a_hold is high, A still wins and hold_err sets. Only rst clears hold_err.
- hit1 is high when addr1 != 0 and addr1 matches either of:
  - the registered write port while wr = 1;
  - any valid FIFO entry.
- hit2 follows the same rule for addr2. Both flags are combinational from registered state and the inputs.
- Write-after-write ordering between A and B to the same register is the upstream's responsibility. Upstream uses the hit flags to enforce it.

## Timing
- A latency: a_valid in cycle N gives wr/addr3/data3 in cycle N+1. The register file captures the write at the end of N+1.
- B minimum latency: accepted at the end of cycle N, wr in cycle N+2 when A is idle in N+1.
- Throughput: one write per cycle. With a_valid held continuously, B drains at least one entry per STARVE_LIMIT+1 cycles, provided upstream honors a_hold.
- Reset values (applied on the rst edge, overriding all traffic in that cycle):
  - wr = 0, addr3 = 0, data3 = 0;
  - count = 0, pointers = 0, starvation counter = 0;
  - hold_err = 0.
- After reset, b_ready = 1, a_hold = 0, hit1 = hit2 = 0.
- Reset mid-operation drops all pending B entries silently.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked only by count.

## Test plan
- **A only.** a_valid = 1, a_addr = 10, a_data = 0000FFFF for one cycle. Expect wr = 1, addr3 = 10, data3 = 0000FFFF in the next cycle, then wr = 0. hit1 is high during the wr cycle when addr1 = 10.
- **B buffering and order.** Push B writes (14, FF00), (31, AAAA), (1, 8888) with a_valid = 0. Expect wr pulses in FIFO order, the first two cycles after its acceptance. count peaks at 2 or lower. hit2 is high for addr2 = 31 until its wr cycle ends.
- **Full.** Hold a_valid = 1 (addr 5) and push 4 B entries. Expect b_ready = 0 once count = 4. A fifth b_valid is not accepted. count never exceeds 4.
- **Starvation.** With the FIFO holding 1 entry and a_valid = 1 continuously, expect a_hold = 1 after 8 A-win cycles. Drop a_valid for one cycle: the entry pops, a_hold = 0. Keeping a_valid high instead sets hold_err = 1 and A still writes.
- **$0 and reset.** a_addr = 0 or b_addr = 0 produces no wr pulse and no enqueue, and hit flags stay low for address 0. Asserting rst with 3 entries queued gives count = 0, wr = 0, b_ready = 1 at the next edge, and no queued write ever appears.
